// File: rtl/win_integrator_pkg.sv
// Shared types and width helpers for the windowed integrator.
package win_integrator_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    STALL = 1'b1
  } state_e;

  // Width of x*SCALE: enough bits for (2^in_w - 1) * scale.
  function automatic int prod_width(input int in_w, input int scale);
    return in_w + $clog2(scale + 1);
  endfunction

endpackage

// File: rtl/win_integrator_scale.sv
// Combinational constant multiplier: p = x * SCALE at full product width.
module win_integrator_scale
  import win_integrator_pkg::*;
#(
  parameter int IN_W   = 4,
  parameter int SCALE  = 25,
  parameter int PROD_W = prod_width(IN_W, SCALE)
) (
  input  logic [IN_W-1:0]   x,
  output logic [PROD_W-1:0] p
);

  assign p = PROD_W'(x) * PROD_W'(SCALE);

endmodule

// File: rtl/win_integrator.sv
// Windowed integrator: sums SCALE*x over WIN_LEN accepted samples into a one-deep output register.
// Build option WIN_INTEGRATOR_SAT_EN: saturate the accumulator and report ovf; otherwise wrap, ovf stays 0.
module win_integrator
  import win_integrator_pkg::*;
#(
  parameter int IN_W    = 4,
  parameter int SCALE   = 25,
  parameter int WIN_LEN = 8,
  parameter int ACC_W   = 13
) (
  input  logic             clock,
  input  logic             acc_rst2,
  input  logic             clr,
  input  logic             x_valid,
  input  logic [IN_W-1:0]  x,
  output logic             x_ready,
  output logic [ACC_W-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             ovf
);

  localparam int PROD_W = prod_width(IN_W, SCALE);
  localparam int CNT_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [ACC_W-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic             win_ovf_q, win_ovf_d;
  logic             ovf_q, ovf_d;

  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  acc_nxt;
  logic              ovf_ev;
  logic              take, last, hs, block, acc_en;

  win_integrator_scale #(
    .IN_W  (IN_W),
    .SCALE (SCALE),
    .PROD_W(PROD_W)
  ) u_scale (
    .x(x),
    .p(prod)
  );

`ifdef WIN_INTEGRATOR_SAT_EN
  localparam int SUM_W = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;
  logic [SUM_W-1:0] sum;
  assign sum     = SUM_W'(acc_q) + SUM_W'(prod);
  assign ovf_ev  = |sum[SUM_W-1:ACC_W];
  assign acc_nxt = ovf_ev ? '1 : sum[ACC_W-1:0];
`else
  assign ovf_ev  = 1'b0;
  assign acc_nxt = acc_q + ACC_W'(prod);
`endif

  assign x_ready = (state_q == ACCUM);
  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign ovf     = ovf_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    win_cnt_d = win_cnt_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    win_ovf_d = win_ovf_q;
    ovf_d     = ovf_q;

    hs     = y_valid_q && y_ready;
    take   = x_valid && (state_q == ACCUM);
    last   = (win_cnt_q == CNT_W'(WIN_LEN - 1));
    // A completing sample with a result still held is refused and parks the FSM.
    block  = take && last && y_valid_q && !y_ready;
    acc_en = take && !block;

    if (hs) begin
      y_valid_d = 1'b0;
      ovf_d     = 1'b0;
    end

    case (state_q)
      ACCUM:   if (block) state_d = STALL;
      STALL:   if (hs)    state_d = ACCUM;
      default: state_d = ACCUM;
    endcase

    if (acc_en) begin
      if (last) begin
        y_d       = acc_nxt;
        y_valid_d = 1'b1;
        ovf_d     = win_ovf_q | ovf_ev;
        acc_d     = '0;
        win_cnt_d = '0;
        win_ovf_d = 1'b0;
      end else begin
        acc_d     = acc_nxt;
        win_cnt_d = win_cnt_q + CNT_W'(1);
        win_ovf_d = win_ovf_q | ovf_ev;
      end
    end

    // y is deliberately left alone so downstream keeps its last value.
    if (clr) begin
      state_d   = ACCUM;
      acc_d     = '0;
      win_cnt_d = '0;
      y_valid_d = 1'b0;
      win_ovf_d = 1'b0;
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge acc_rst2) begin
    if (acc_rst2) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      win_cnt_q <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      win_ovf_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      win_cnt_q <= win_cnt_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      win_ovf_q <= win_ovf_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_win_integrator.sv
// Scoreboard bench for win_integrator: default instance plus an ACC_W=10 instance for overflow behaviour.
module tb_win_integrator;

  logic        clock;
  logic        acc_rst2;
  logic        clr;
  logic        x_valid;
  logic [3:0]  x;
  logic        x_ready;
  logic [12:0] y;
  logic        y_valid;
  logic        y_ready;
  logic        ovf;

  logic        clr2;
  logic        x_valid2;
  logic [3:0]  x2;
  logic        x_ready2;
  logic [9:0]  y2;
  logic        y_valid2;
  logic        y_ready2;
  logic        ovf2;

  int tests = 0;
  int fails = 0;
  logic [12:0] sb[$];
  logic [12:0] exp_y;

`ifdef WIN_INTEGRATOR_SAT_EN
  localparam logic [9:0] EXP_Y2   = 10'd1023;
  localparam logic       EXP_OVF2 = 1'b1;
`else
  localparam logic [9:0] EXP_Y2   = 10'd952;
  localparam logic       EXP_OVF2 = 1'b0;
`endif

  win_integrator dut (
    .clock(clock), .acc_rst2(acc_rst2), .clr(clr),
    .x_valid(x_valid), .x(x), .x_ready(x_ready),
    .y(y), .y_valid(y_valid), .y_ready(y_ready), .ovf(ovf)
  );

  win_integrator #(.ACC_W(10)) dut2 (
    .clock(clock), .acc_rst2(acc_rst2), .clr(clr2),
    .x_valid(x_valid2), .x(x2), .x_ready(x_ready2),
    .y(y2), .y_valid(y_valid2), .y_ready(y_ready2), .ovf(ovf2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Each output handshake is checked against the oldest expected result.
  always @(negedge clock) begin
    if (!acc_rst2 && y_valid && y_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected y=%0d expected no result", y);
      end else begin
        exp_y = sb.pop_front();
        if (y !== exp_y) begin
          fails++;
          $display("FAIL sb_result y=%0d expected %0d", y, exp_y);
        end
      end
    end
  end

  // Offer one sample and hold it until taken; returns the number of cycles spent.
  task automatic send(input logic [3:0] v, output int n);
    logic rdy;
    bit done;
    n = 0;
    done = 0;
    x_valid = 1'b1;
    x = v;
    while (!done) begin
      @(negedge clock);
      rdy = x_ready;
      @(posedge clock);
      #1;
      n++;
      if (rdy && x_ready) done = 1;
      if (!done && n > 200) begin
        tests++;
        fails++;
        $display("FAIL send_timeout cycles=%0d expected accept", n);
        done = 1;
      end
    end
    x_valid = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (y !== 13'd0)  begin fails++; $display("FAIL rst_y y=%0d expected 0", y); end
    tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL rst_y_valid got %b expected 0", y_valid); end
    tests++; if (x_ready !== 1'b1) begin fails++; $display("FAIL rst_x_ready got %b expected 1", x_ready); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL rst_ovf got %b expected 0", ovf); end
    tests++; if (y2 !== 10'd0) begin fails++; $display("FAIL rst_y2 y=%0d expected 0", y2); end
  endtask

  task automatic test_basic();
    logic [3:0] s[8] = '{4'd10, 4'd5, 4'd12, 4'd1, 4'd13, 4'd7, 4'd9, 4'd2};
    int n;
    y_ready = 1'b1;
    sb.push_back(13'd1475);
    for (int i = 0; i < 8; i++) begin
      send(s[i], n);
      tests++;
      if (n != 1) begin fails++; $display("FAIL basic_x_ready sample %0d took %0d cycles expected 1", i, n); end
    end
    tests++; if (y_valid !== 1'b1 || y !== 13'd1475) begin
      fails++; $display("FAIL basic_out y=%0d v=%b expected 1475 v=1", y, y_valid); end
    @(posedge clock); #1;
    tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL basic_one_cycle v=%b expected 0", y_valid); end
  endtask

  task automatic test_stall();
    int n;
    y_ready = 1'b0;
    sb.push_back(13'd3000);
    for (int i = 0; i < 8; i++) send(4'd15, n);
    for (int i = 0; i < 7; i++) send(4'd15, n);
    x_valid = 1'b1;
    x = 4'd15;
    @(posedge clock); #1;
    tests++; if (x_ready !== 1'b0) begin fails++; $display("FAIL stall_enter x_ready=%b expected 0", x_ready); end
    tests++; if (y !== 13'd3000 || y_valid !== 1'b1) begin
      fails++; $display("FAIL stall_hold y=%0d v=%b expected 3000 v=1", y, y_valid); end
    repeat (3) @(posedge clock);
    #1;
    tests++; if (x_ready !== 1'b0) begin fails++; $display("FAIL stall_stay x_ready=%b expected 0", x_ready); end
    y_ready = 1'b1;
    sb.push_back(13'd3000);
    @(posedge clock); #1;
    tests++; if (x_ready !== 1'b1 || y_valid !== 1'b0) begin
      fails++; $display("FAIL stall_exit x_ready=%b v=%b expected 1 0", x_ready, y_valid); end
    @(posedge clock); #1;
    x_valid = 1'b0;
    tests++; if (y_valid !== 1'b1 || y !== 13'd3000) begin
      fails++; $display("FAIL stall_resume y=%0d v=%b expected 3000 v=1", y, y_valid); end
    @(posedge clock); #1;
  endtask

  task automatic test_rst_mid();
    int n;
    for (int i = 0; i < 4; i++) send(4'd3, n);
    #2 acc_rst2 = 1'b1;
    #1;
    tests++; if (y !== 13'd0 || y_valid !== 1'b0 || x_ready !== 1'b1) begin
      fails++; $display("FAIL rst_mid y=%0d v=%b xr=%b expected 0 0 1", y, y_valid, x_ready); end
    @(negedge clock);
    acc_rst2 = 1'b0;
    @(posedge clock); #1;
    sb.push_back(13'd200);
    for (int i = 0; i < 8; i++) send(4'd1, n);
    tests++; if (y !== 13'd200 || y_valid !== 1'b1) begin
      fails++; $display("FAIL rst_fresh y=%0d v=%b expected 200 v=1", y, y_valid); end
    @(posedge clock); #1;
  endtask

  task automatic test_clr();
    int n;
    for (int i = 0; i < 3; i++) send(4'd4, n);
    clr = 1'b1;
    x_valid = 1'b1;
    x = 4'd9;
    @(posedge clock); #1;
    clr = 1'b0;
    x_valid = 1'b0;
    tests++; if (y !== 13'd200 || y_valid !== 1'b0 || x_ready !== 1'b1) begin
      fails++; $display("FAIL clr_state y=%0d v=%b xr=%b expected 200 0 1", y, y_valid, x_ready); end
    sb.push_back(13'd400);
    for (int i = 0; i < 8; i++) send(4'd2, n);
    tests++; if (y !== 13'd400 || y_valid !== 1'b1) begin
      fails++; $display("FAIL clr_window y=%0d v=%b expected 400 v=1", y, y_valid); end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    int n;
    int slow = 0;
    y_ready = 1'b0;
    sb.push_back(13'd1200);
    sb.push_back(13'd2200);
    for (int i = 0; i < 8; i++) begin send(4'd6, n); if (n != 1) slow++; end
    for (int i = 0; i < 7; i++) begin send(4'd11, n); if (n != 1) slow++; end
    y_ready = 1'b1;
    send(4'd11, n);
    if (n != 1) slow++;
    tests++; if (slow != 0) begin fails++; $display("FAIL b2b_x_ready slow_accepts=%0d expected 0", slow); end
    tests++; if (y_valid !== 1'b1 || y !== 13'd2200) begin
      fails++; $display("FAIL b2b_out y=%0d v=%b expected 2200 v=1", y, y_valid); end
    @(posedge clock); #1;
    tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain v=%b expected 0", y_valid); end
  endtask

  task automatic test_ovf();
    x_valid2 = 1'b1;
    x2 = 4'd15;
    repeat (8) @(posedge clock);
    #1;
    x_valid2 = 1'b0;
    tests++; if (y2 !== EXP_Y2 || y_valid2 !== 1'b1) begin
      fails++; $display("FAIL ovf_result y=%0d v=%b expected %0d v=1", y2, y_valid2, EXP_Y2); end
    tests++; if (ovf2 !== EXP_OVF2) begin fails++; $display("FAIL ovf_flag got %b expected %b", ovf2, EXP_OVF2); end
    y_ready2 = 1'b1;
    @(posedge clock); #1;
    y_ready2 = 1'b0;
    tests++; if (y_valid2 !== 1'b0 || ovf2 !== 1'b0 || y2 !== EXP_Y2) begin
      fails++; $display("FAIL ovf_drain y=%0d v=%b ovf=%b expected %0d 0 0", y2, y_valid2, ovf2, EXP_Y2); end
  endtask

  initial begin
    acc_rst2 = 1'b1;
    clr = 1'b0; x_valid = 1'b0; x = '0; y_ready = 1'b1;
    clr2 = 1'b0; x_valid2 = 1'b0; x2 = '0; y_ready2 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    @(negedge clock);
    acc_rst2 = 1'b0;
    @(posedge clock); #1;
    test_basic();
    test_stall();
    test_rst_mid();
    test_clr();
    test_back_to_back();
    test_ovf();
    repeat (2) @(posedge clock);
    #1;
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL sb_leftover pending=%0d expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
